// File: rtl/vout_spipoti_pkg.sv
// Shared constants for the SPI potentiometer scheduler: FSM encoding and frame length.
package vout_spipoti_pkg;
  localparam int FRAME_LEN = 16;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOW   = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
endpackage

// File: rtl/vout_spipoti_shift.sv
// Frame serializer: owns the frame FSM, shifts a 16-bit word out MSB first
// with SCLK idle low, and reports the TRAIL tick so the arbiter can commit.
//
// state    | meaning
// ST_IDLE  | no frame; waiting for a tick with a pending channel
// ST_LOW   | CS low, MOSI valid, SCLK low
// ST_HIGH  | SCLK high, device samples MOSI
// ST_TRAIL | last bit done, SCLK low, CS still low
// ST_GAP   | CS released, one idle tick before next frame
module vout_spipoti_shift
  import vout_spipoti_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [FRAME_LEN-1:0] word,
  output state_t               state,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_act,
  output logic                 done
);
  localparam int BW = $clog2(FRAME_LEN);

  logic [FRAME_LEN-1:0] sr;
  logic [BW-1:0]        bit_cnt;

  assign done = tick && (state == ST_TRAIL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_act  <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_IDLE: if (start) begin
          sr      <= word;
          mosi    <= word[FRAME_LEN-1];
          sclk    <= 1'b0;
          cs_act  <= 1'b1;
          bit_cnt <= BW'(FRAME_LEN - 1);
          state   <= ST_LOW;
        end
        ST_LOW: begin
          sclk  <= 1'b1;
          state <= ST_HIGH;
        end
        ST_HIGH: begin
          sclk <= 1'b0;
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
            sr      <= sr << 1;
            mosi    <= sr[FRAME_LEN-2];
            state   <= ST_LOW;
          end else begin
            mosi  <= 1'b0;
            state <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          cs_act <= 1'b0;
          state  <= ST_GAP;
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vout_spipoti_sched.sv
// Round-robin scheduler writing changed channel values to SPI digital pots
// over a shared bus; shadows track the last value actually sent per channel.
module vout_spipoti_sched
  import vout_spipoti_pkg::*;
#(
  parameter int         CHANNELS = 4,
  parameter int         DIV      = 100,
  parameter logic [7:0] CMD      = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS*8-1:0] values,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic [CHANNELS-1:0]   CS_N,
  output logic                  busy
);
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = $clog2(DIV);

  logic [CW-1:0]       tick_cnt;
  logic                tick;
  logic [7:0]          shadow [CHANNELS];
  logic [CHANNELS-1:0] force_f;
  logic [CHANNELS-1:0] pend;
  logic                any_pend;
  logic [SW-1:0]       last, sel, nxt_sel;
  logic [7:0]          nxt_val, lat_val;
  state_t              state;
  logic                cs_act, done, launch;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= CW'(DIV - 1);
    else             tick_cnt <= tick_cnt - 1'b1;
  end

  // A value that returns to its shadow drops out of pend on its own.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      pend[i] = (values[8*i +: 8] != shadow[i]) || force_f[i];
  end

  // Descending scan so the closest pending channel after 'last' wins.
  always_comb begin
    any_pend = |pend;
    nxt_sel  = last;
    nxt_val  = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      if (pend[(int'(last) + k) % CHANNELS]) begin
        nxt_sel = SW'((int'(last) + k) % CHANNELS);
        nxt_val = values[8*((int'(last) + k) % CHANNELS) +: 8];
      end
    end
  end

  assign launch = tick && (state == ST_IDLE) && any_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= SW'(CHANNELS - 1);
      sel     <= '0;
      lat_val <= '0;
      force_f <= '1;
      for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
    end else begin
      if (launch) begin
        sel     <= nxt_sel;
        lat_val <= nxt_val;
      end
      if (done) begin
        shadow[sel]  <= lat_val;
        force_f[sel] <= 1'b0;
        last         <= sel;
      end
    end
  end

  vout_spipoti_shift u_shift (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .start  (any_pend),
    .word   ({CMD, nxt_val}),
    .state  (state),
    .sclk   (SCLK),
    .mosi   (MOSI),
    .cs_act (cs_act),
    .done   (done)
  );

  always_comb begin
    CS_N = '1;
    if (cs_act) CS_N[sel] = 1'b0;
  end

  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_vout_spipoti_sched.sv
// Bench for vout_spipoti_sched: scoreboard of expected frames against a bus monitor.
module tb_vout_spipoti_sched;
  localparam int CH  = 4;
  localparam int DIV = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH*8-1:0] values = '0;
  logic            MOSI, SCLK, busy;
  logic [CH-1:0]   CS_N;

  typedef struct { int ch; logic [15:0] word; } frame_t;
  frame_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  vout_spipoti_sched #(.CHANNELS(CH), .DIV(DIV), .CMD(8'h00)) dut (
    .clk(clk), .rst(rst), .values(values),
    .MOSI(MOSI), .SCLK(SCLK), .CS_N(CS_N), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] v);
    frame_t f;
    f.ch = ch;
    f.word = {8'h00, v};
    sb.push_back(f);
  endtask

  // Bus monitor: decodes each frame and checks it against the scoreboard.
  logic          in_frame = 1'b0;
  logic          sclk_q = 1'b0;
  logic [CH-1:0] cs_q = '1;
  int            cs_len, rises, mon_ch;
  logic [15:0]   mword;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      check_val("cs_onehot", 32'($countones(~CS_N) <= 1), 32'd1);
      if (sclk_q && SCLK) check_val("cs_stable", 32'(CS_N), 32'(cs_q));
      if (!in_frame && CS_N != '1) begin
        in_frame = 1'b1;
        cs_len = 1;
        rises = 0;
        mword = '0;
        mon_ch = -1;
        for (int i = 0; i < CH; i++) if (!CS_N[i]) mon_ch = i;
      end else if (in_frame) begin
        if (CS_N == '1) begin
          frame_t e;
          in_frame = 1'b0;
          check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val("frame_ch", 32'(mon_ch), 32'(e.ch));
            check_val("frame_word", 32'(mword), 32'(e.word));
            check_val("sclk_rises", 32'(rises), 32'd16);
            check_val("cs_low_cycles", 32'(cs_len), 32'(33 * DIV));
          end
        end else begin
          cs_len++;
          if (SCLK && !sclk_q) begin
            rises++;
            mword = {mword[14:0], MOSI};
          end
        end
      end
    end
    sclk_q = SCLK;
    cs_q = CS_N;
  end

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 10 && n < budget) begin
      @(negedge clk);
      n++;
      if (sb.size() == 0 && !busy) quiet++;
      else quiet = 0;
    end
    check_val("idle_reached", 32'(quiet), 32'd10);
  endtask

  task automatic wait_cs_low(input int ch, input int budget);
    int n = 0;
    while (CS_N[ch] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("cs_wait", 32'(CS_N[ch]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then the post-reset sweep of all channels.
    repeat (3) @(negedge clk);
    check_val("rst_cs_n", 32'(CS_N), 32'hF);
    check_val("rst_sclk", 32'(SCLK), 32'd0);
    check_val("rst_mosi", 32'(MOSI), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < CH; i++) push(i, 8'h00);
    rst = 1'b0;
    wait_idle(2000);

    // Single change on channel 2.
    values[8*2 +: 8] = 8'hA5;
    push(2, 8'hA5);
    wait_idle(1000);

    // Simultaneous change on 1 and 3 after serving 2: 3 wins, then 1.
    values[8*1 +: 8] = 8'h3C;
    values[8*3 +: 8] = 8'hC3;
    push(3, 8'hC3);
    push(1, 8'h3C);
    wait_idle(1000);

    // Mid-frame change on channel 0, plus a toggle on 1 that reverts unseen.
    values[8*0 +: 8] = 8'h10;
    push(0, 8'h10);
    wait_cs_low(0, 200);
    repeat (6) @(negedge clk);
    values[8*0 +: 8] = 8'h20;
    push(0, 8'h20);
    values[8*1 +: 8] = 8'h55;
    repeat (4) @(negedge clk);
    values[8*1 +: 8] = 8'h3C;
    wait_idle(1000);

    // Reset in the middle of a frame on channel 2.
    values[8*2 +: 8] = 8'h5A;
    wait_cs_low(2, 200);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_cs_n", 32'(CS_N), 32'hF);
    check_val("abort_sclk", 32'(SCLK), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    push(0, 8'h20);
    push(1, 8'h3C);
    push(2, 8'h5A);
    push(3, 8'hC3);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(2000);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vout_spipoti_sched.md
VOUT_SPIPOTI_SCHED -- requirements
Module: vout_spipoti_sched

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of potentiometer channels sharing one SPI bus (2..8).
REQ-002 SHALL have parameter DIV, default 100, clk cycles per bit-phase tick (>=2).
REQ-003 SHALL have parameter CMD, default 8'h00, command byte sent before each value.
REQ-004 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port values  in  CHANNELS*8  channel n value in bits [8n+7:8n].
REQ-007 SHALL have port MOSI  out  1  serial data, MSB first.
REQ-008 SHALL have port SCLK  out  1  serial clock, idle low, data sampled by the device on the rising edge.
REQ-009 SHALL have port CS_N  out  CHANNELS  per-channel chip select, active low.
REQ-010 SHALL have port busy  out  1  high while a frame is in progress (state not IDLE).

Function
REQ-011 SHALL generate a one-cycle tick every DIV clk cycles from a free-running down-counter; all state transitions occur only on tick.
REQ-012 SHALL hold per channel a shadow register (last value sent) and a pending flag; pending = (value != shadow) or force flag.
REQ-013 SHALL set the force flag for every channel at reset, so all channels are written once after reset.
REQ-014 SHALL have states IDLE, LOW, HIGH, TRAIL, GAP.
REQ-015 IDLE, on tick with any pending: select the first pending channel strictly after the last-served channel (round-robin, wrap CHANNELS-1 -> 0), latch word {CMD, value}, drive CS_N[sel]=0, MOSI=bit15, SCLK=0, go to LOW.
REQ-016 IDLE, on tick with no pending: remain in IDLE, outputs idle.
REQ-017 LOW, on tick: SCLK=1, go to HIGH.
REQ-018 HIGH, on tick: SCLK=0; if bits remain, MOSI=next bit and go to LOW; after bit 0, MOSI=0 and go to TRAIL.
REQ-019 TRAIL, on tick: CS_N all ones, shadow[sel] = latched value, force[sel] cleared, last-served = sel, go to GAP.
REQ-020 GAP, on tick: go to IDLE.
REQ-021 Frame timing in ticks from CS assert (t0): SCLK rises at t1,3,...,31, falls at t2,...,32; CS_N deasserts at t33; next frame starts no earlier than t35.
REQ-022 A value change during a frame SHALL NOT alter the frame in flight; the channel becomes pending again after TRAIL if its value differs from the sent one.
REQ-023 At most one CS_N bit SHALL be low at any time; CS_N SHALL change only while SCLK is low.
REQ-024 A channel whose value toggles and returns to its shadow value before being selected SHALL NOT be written.

Reset
REQ-025 On rst: state IDLE, SCLK=0, MOSI=0, CS_N all ones, busy=0, tick counter reloaded, last-served = CHANNELS-1, shadows 0, all force flags set.
REQ-026 rst mid-frame SHALL abort the frame at the next clk edge with CS_N all ones and no shadow update.

Structure
REQ-027 State encoding and frame length (16) SHALL be in a shared package vout_spipoti_pkg.
REQ-028 The serializer (LOW/HIGH/TRAIL shift logic) SHALL be a sub-module vout_spipoti_shift; arbitration, shadows and tick generation stay in the top.

Verification
REQ-029 Reset release, CHANNELS=4, DIV=2, values all 8'h00 -> four frames, CS_N[0..3] in order, each word 16'h0000, then idle.
REQ-030 After idle, set channel 2 to 8'hA5 -> one frame on CS_N[2] with MOSI bits 0x00A5, 16 SCLK rising edges, CS_N low exactly 33 ticks.
REQ-031 Channels 1 and 3 change in the same cycle, last served 2 -> channel 3 served first, then 1.
REQ-032 Change channel 0 to 8'h10 then 8'h20 mid-frame on 0 -> current frame sends 8'h10, a second frame sends 8'h20.
REQ-033 rst asserted at tick 10 of a frame -> CS_N all ones and SCLK=0 next cycle; afterwards all channels rewritten.
REQ-034 Throughout all tests assert at most one CS_N low and CS_N stable while SCLK high.
